int_commit_sequencer: RTL and testbench
=======================================

Name: int_commit_sequencer

Overview:
- Accepts up to NREQ same-cycle integer commits from the ROB commit slots and serialises them onto the single integer register-file write port.
- Slot 0 is the oldest in a cycle. In-order write semantics are kept by pushing the valid slots, in index order, into one shared FIFO that drains one entry per cycle.
- Sits between ROB commit logic and the integer regfile. The output side drives the valid/wren/data/rdindex commit signal set.

Parameters:
- NREQ, 2, number of commit slots presented per cycle (1..4).
- DEPTH, 4, FIFO entries; power of two, must be >= NREQ.
- XLEN, 64, data width; tracks `XLEN.

Ports:
- clk_i  in  1  clock.
- arst_n_i  in  1  reset, asynchronous, active-low.
- cmt_valid_i  in  NREQ  per-slot commit valid; bit 0 is the oldest.
- cmt_wren_i  in  NREQ  per-slot register write enable.
- cmt_data_i  in  NREQ*XLEN  per-slot write data; slot k occupies bits [k*XLEN +: XLEN].
- cmt_rdindex_i  in  NREQ*5  per-slot destination index; slot k occupies bits [k*5 +: 5].
- cmt_ready_o  out  1  all slots accepted this cycle when high.
- rf_valid_o  out  1  commit presented to the regfile.
- rf_wren_o  out  1  regfile write enable.
- rf_data_o  out  XLEN  regfile write data.
- rf_rdindex_o  out  5  regfile write index.
- empty_o  out  1  FIFO empty; used by fence/interrupt-wait logic.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- One clock. Reset is asynchronous and active-low; all state clears on arst_n_i low, independent of clk_i.
- Reset values:
  - wr_ptr, rd_ptr, count = 0.
  - rf_valid_o = 0, rf_wren_o = 0, rf_data_o = 0, rf_rdindex_o = 0.
  - empty_o = 1, count_o = 0, cmt_ready_o = 1 (DEPTH >= NREQ).
- Ready: cmt_ready_o = (DEPTH - count) >= NREQ. This uses registered count only; the same-cycle pop is not credited. The all-or-nothing rule preserves slot order.
- Push (when cmt_ready_o = 1):
  - Each slot with cmt_valid_i = 1 is written at consecutive FIFO locations from wr_ptr, in ascending slot index.
  - Non-valid slots are skipped (compaction). Example: only slot 1 valid → one entry at wr_ptr.
  - wr_ptr advances by popcount(cmt_valid_i), modulo DEPTH.
- If cmt_ready_o = 0, valid slots are ignored and no state changes. The ROB must hold them.
- Output:
  - rf_valid_o = !empty. rf_wren_o = head.wren && (head.rdindex != 0); x0 writes are suppressed but still retire.
  - rf_data_o / rf_rdindex_o = head fields. When empty, these outputs are 0.
- Pop: the head is removed every cycle rf_valid_o = 1; the regfile port never back-pressures. rd_ptr increments modulo DEPTH.
- Latency: a commit pushed in cycle N appears on rf_* in cycle N+1 at the earliest; there is no combinational input-to-output path.
- Simultaneous push and pop: count_next = count + popcount(valid & {NREQ{ready}}) - pop.
- Pointers wrap naturally at DEPTH. count never exceeds DEPTH.
- Reset mid-operation discards all queued entries; rf_valid_o drops asynchronously.

Optional Feature:
- Macro: INT_COMMIT_PERF_EN.
- When defined, two extra outputs are added:
  - perf_stall_o (32): counts cycles with |cmt_valid_i && !cmt_ready_o.
  - perf_commit_o (32): counts cycles with rf_valid_o = 1.
  - Both saturate at 0xFFFF_FFFF and reset to 0.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
1. Reset release, no stimulus → rf_valid_o = 0, empty_o = 1, count_o = 0, cmt_ready_o = 1.
2. Cycle 1: valid = 2'b11, slot0 = (rd 5, 0xA), slot1 = (rd 5, 0xB) → cycle 2: rf rd 5 data 0xA; cycle 3: rf rd 5 data 0xB; cycle 4: empty_o = 1.
3. valid = 2'b10, slot1 = (rd 7, 0x1234, wren 1) → next cycle: rf_valid_o = 1, rdindex 7, data 0x1234; count_o peaks at 1.
4. valid = 2'b11 for 4 consecutive cycles (DEPTH 4) → cmt_ready_o goes low once count = 3, and each pair is accepted only when count <= 2. The output stream is uninterrupted, in slot/age order, with no loss or duplication.
5. Commit with wren 1, rd 0, data 0xFF → rf_valid_o = 1, rf_wren_o = 0.
6. Assert arst_n_i mid-stream with count = 3 → outputs clear immediately. After release, count_o = 0 and no stale entry appears. With INT_COMMIT_PERF_EN, perf_stall_o matches the number of cycles cmt_ready_o was low while valid was asserted in scenario 4.

Source files
------------

// File: rtl/int_commit_sequencer_if.sv
// Signal bundle between ROB commit slots and the integer regfile write port.
// The slave modport is the sequencer; the master modport is the ROB/regfile side.
// The default data width is 64.
interface int_commit_sequencer_if #(
  parameter int NREQ  = 2,
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NREQ-1:0]      cmt_valid_i;
  logic [NREQ-1:0]      cmt_wren_i;
  logic [NREQ*XLEN-1:0] cmt_data_i;
  logic [NREQ*5-1:0]    cmt_rdindex_i;
  logic                 cmt_ready_o;
  logic                 rf_valid_o;
  logic                 rf_wren_o;
  logic [XLEN-1:0]      rf_data_o;
  logic [4:0]           rf_rdindex_o;
  logic                 empty_o;
  logic [CW-1:0]        count_o;

  modport master (
    output cmt_valid_i, cmt_wren_i, cmt_data_i, cmt_rdindex_i,
    input  cmt_ready_o, rf_valid_o, rf_wren_o, rf_data_o, rf_rdindex_o,
           empty_o, count_o
  );

  modport slave (
    input  cmt_valid_i, cmt_wren_i, cmt_data_i, cmt_rdindex_i,
    output cmt_ready_o, rf_valid_o, rf_wren_o, rf_data_o, rf_rdindex_o,
           empty_o, count_o
  );
endinterface

// File: rtl/int_commit_sequencer.sv
// int_commit_sequencer: serialises up to NREQ same-cycle integer commits onto
// the single regfile write port through a shared in-order FIFO.
// Valid slots are compacted and pushed oldest-first; one entry drains per cycle.
// Optional feature macro: INT_COMMIT_PERF_EN adds perf_stall_o / perf_commit_o.
// Interface parameters must match the module parameters at instantiation.
module int_commit_sequencer #(
  parameter int NREQ  = 2,
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  int_commit_sequencer_if.slave bus
`ifdef INT_COMMIT_PERF_EN
  ,
  output logic [31:0]           perf_stall_o,
  output logic [31:0]           perf_commit_o
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   push_cnt;
  logic            ready;
  logic            pop;
  logic [NREQ-1:0] slot_we;
  logic [PW-1:0]   slot_idx [NREQ];

  logic            wren_q  [DEPTH];
  logic [XLEN-1:0] data_q  [DEPTH];
  logic [4:0]      rdidx_q [DEPTH];

  // Accept all slots only when the registered free space covers every slot;
  // the head leaving this cycle is deliberately not credited.
  assign ready = (DEPTH - int'(count_q)) >= NREQ;
  assign pop   = (count_q != '0);

  // Compact the valid slots onto consecutive FIFO locations from the write
  // pointer, in slot order, and derive the next pointer/occupancy values.
  always_comb begin
    push_cnt = '0;
    for (int k = 0; k < NREQ; k++) begin
      slot_we[k]  = 1'b0;
      slot_idx[k] = '0;
      if (ready && bus.cmt_valid_i[k]) begin
        slot_we[k]  = 1'b1;
        slot_idx[k] = PW'((int'(wr_ptr_q) + int'(push_cnt)) % DEPTH);
        push_cnt    = push_cnt + CW'(1);
      end
    end
    wr_ptr_d = PW'((int'(wr_ptr_q) + int'(push_cnt)) % DEPTH);
    rd_ptr_d = pop ? PW'((int'(rd_ptr_q) + 1) % DEPTH) : rd_ptr_q;
    count_d  = count_q + push_cnt - CW'(pop);
  end

  // Pointer and occupancy state; reset discards everything queued.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage: write each accepted slot at its compacted location.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        wren_q[i]  <= 1'b0;
        data_q[i]  <= '0;
        rdidx_q[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (slot_we[k]) begin
          wren_q[slot_idx[k]]  <= bus.cmt_wren_i[k];
          data_q[slot_idx[k]]  <= bus.cmt_data_i[k*XLEN +: XLEN];
          rdidx_q[slot_idx[k]] <= bus.cmt_rdindex_i[k*5 +: 5];
        end
      end
    end
  end

  // Head of the FIFO drives the regfile port straight from state, so there is
  // no input-to-output path; writes to x0 retire without enabling the write.
  assign bus.cmt_ready_o  = ready;
  assign bus.rf_valid_o   = pop;
  assign bus.rf_wren_o    = pop && wren_q[rd_ptr_q] && (rdidx_q[rd_ptr_q] != 5'd0);
  assign bus.rf_data_o    = pop ? data_q[rd_ptr_q] : '0;
  assign bus.rf_rdindex_o = pop ? rdidx_q[rd_ptr_q] : 5'd0;
  assign bus.empty_o      = !pop;
  assign bus.count_o      = count_q;

`ifdef INT_COMMIT_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_commit_q;

  // Saturating counters for back-pressured commit cycles and drained commits.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      perf_stall_q  <= '0;
      perf_commit_q <= '0;
    end else begin
      if ((|bus.cmt_valid_i) && !ready && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (pop && (perf_commit_q != 32'hFFFF_FFFF)) begin
        perf_commit_q <= perf_commit_q + 32'd1;
      end
    end
  end

  assign perf_stall_o  = perf_stall_q;
  assign perf_commit_o = perf_commit_q;
`endif

endmodule

// File: tb/tb_int_commit_sequencer.sv
// Self-checking bench for int_commit_sequencer (NREQ=2, DEPTH=4, XLEN=64):
// directed vector table, randomized run against a queue model, and an
// asynchronous mid-stream reset sequence.
module tb_int_commit_sequencer;

  localparam int NREQ  = 2;
  localparam int DEPTH = 4;
  localparam int XLEN  = 64;

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  wren;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic        eValid;
    logic        eWren;
    logic [63:0] eData;
    logic [4:0]  eRd;
    logic [2:0]  eCount;
    logic        eReady;
  } vec_t;

  typedef struct {
    logic        wren;
    logic [63:0] data;
    logic [4:0]  rd;
  } ent_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

`ifdef INT_COMMIT_PERF_EN
  logic [31:0] perfStall;
  logic [31:0] perfCommit;
`endif

  int_commit_sequencer_if #(.NREQ(NREQ), .DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  int_commit_sequencer #(.NREQ(NREQ), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i    (clk),
    .arst_n_i (rst_n),
    .bus      (bus)
`ifdef INT_COMMIT_PERF_EN
    ,
    .perf_stall_o  (perfStall),
    .perf_commit_o (perfCommit)
`endif
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] wren,
                               input logic [63:0] d0, input logic [63:0] d1,
                               input logic [4:0] r0, input logic [4:0] r1);
    bus.cmt_valid_i   = valid;
    bus.cmt_wren_i    = wren;
    bus.cmt_data_i    = {d1, d0};
    bus.cmt_rdindex_i = {r1, r0};
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, ".rf_valid"}, 64'(bus.rf_valid_o), 64'd0);
    checkOutput({tag, ".rf_wren"},  64'(bus.rf_wren_o),  64'd0);
    checkOutput({tag, ".rf_data"},  bus.rf_data_o,       64'd0);
    checkOutput({tag, ".rf_rd"},    64'(bus.rf_rdindex_o), 64'd0);
    checkOutput({tag, ".empty"},    64'(bus.empty_o),    64'd1);
    checkOutput({tag, ".count"},    64'(bus.count_o),    64'd0);
    checkOutput({tag, ".ready"},    64'(bus.cmt_ready_o), 64'd1);
  endtask

  vec_t vecs[$];
  ent_t model[$];

  initial begin
    logic [1:0]  v, w;
    logic [63:0] d0, d1;
    logic [4:0]  r0, r1;
    logic        mReady;
    ent_t        e;

    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    applyStimulus(2'b00, 2'b00, 64'd0, 64'd0, 5'd0, 5'd0);

    // Pair A/B to rd 5, single slot-1 commit, x0 write, then four held pairs.
    vecs.push_back('{2'b11, 2'b11, 64'hA,    64'hB,      5'd5, 5'd5, 1'b1, 1'b1, 64'hA,    5'd5, 3'd2, 1'b1});
    vecs.push_back('{2'b00, 2'b00, 64'h0,    64'h0,      5'd0, 5'd0, 1'b1, 1'b1, 64'hB,    5'd5, 3'd1, 1'b1});
    vecs.push_back('{2'b00, 2'b00, 64'h0,    64'h0,      5'd0, 5'd0, 1'b0, 1'b0, 64'h0,    5'd0, 3'd0, 1'b1});
    vecs.push_back('{2'b10, 2'b11, 64'hDEAD, 64'h1234,   5'd3, 5'd7, 1'b1, 1'b1, 64'h1234, 5'd7, 3'd1, 1'b1});
    vecs.push_back('{2'b00, 2'b00, 64'h0,    64'h0,      5'd0, 5'd0, 1'b0, 1'b0, 64'h0,    5'd0, 3'd0, 1'b1});
    vecs.push_back('{2'b01, 2'b01, 64'hFF,   64'h0,      5'd0, 5'd0, 1'b1, 1'b0, 64'hFF,   5'd0, 3'd1, 1'b1});
    vecs.push_back('{2'b00, 2'b00, 64'h0,    64'h0,      5'd0, 5'd0, 1'b0, 1'b0, 64'h0,    5'd0, 3'd0, 1'b1});
    vecs.push_back('{2'b11, 2'b11, 64'h10,   64'h11,     5'd1, 5'd2, 1'b1, 1'b1, 64'h10,   5'd1, 3'd2, 1'b1});
    vecs.push_back('{2'b11, 2'b11, 64'h20,   64'h21,     5'd3, 5'd4, 1'b1, 1'b1, 64'h11,   5'd2, 3'd3, 1'b0});
    vecs.push_back('{2'b11, 2'b11, 64'h30,   64'h31,     5'd5, 5'd6, 1'b1, 1'b1, 64'h20,   5'd3, 3'd2, 1'b1});
    vecs.push_back('{2'b11, 2'b11, 64'h30,   64'h31,     5'd5, 5'd6, 1'b1, 1'b1, 64'h21,   5'd4, 3'd3, 1'b0});
    vecs.push_back('{2'b11, 2'b11, 64'h40,   64'h41,     5'd7, 5'd8, 1'b1, 1'b1, 64'h30,   5'd5, 3'd2, 1'b1});
    vecs.push_back('{2'b11, 2'b11, 64'h40,   64'h41,     5'd7, 5'd8, 1'b1, 1'b1, 64'h31,   5'd6, 3'd3, 1'b0});
    vecs.push_back('{2'b00, 2'b00, 64'h0,    64'h0,      5'd0, 5'd0, 1'b1, 1'b1, 64'h40,   5'd7, 3'd2, 1'b1});
    vecs.push_back('{2'b00, 2'b00, 64'h0,    64'h0,      5'd0, 5'd0, 1'b1, 1'b1, 64'h41,   5'd8, 3'd1, 1'b1});
    vecs.push_back('{2'b00, 2'b00, 64'h0,    64'h0,      5'd0, 5'd0, 1'b0, 1'b0, 64'h0,    5'd0, 3'd0, 1'b1});

    // Reset state, both during and after reset.
    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkIdleOutputs("post_reset");

    // Directed vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].valid, vecs[i].wren, vecs[i].d0, vecs[i].d1, vecs[i].r0, vecs[i].r1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d.rf_valid", i), 64'(bus.rf_valid_o),   64'(vecs[i].eValid));
      checkOutput($sformatf("vec%0d.rf_wren", i),  64'(bus.rf_wren_o),    64'(vecs[i].eWren));
      checkOutput($sformatf("vec%0d.rf_data", i),  bus.rf_data_o,         vecs[i].eData);
      checkOutput($sformatf("vec%0d.rf_rd", i),    64'(bus.rf_rdindex_o), 64'(vecs[i].eRd));
      checkOutput($sformatf("vec%0d.count", i),    64'(bus.count_o),      64'(vecs[i].eCount));
      checkOutput($sformatf("vec%0d.ready", i),    64'(bus.cmt_ready_o),  64'(vecs[i].eReady));
      checkOutput($sformatf("vec%0d.empty", i),    64'(bus.empty_o),      64'(!vecs[i].eValid));
    end
    applyStimulus(2'b00, 2'b00, 64'd0, 64'd0, 5'd0, 5'd0);

`ifdef INT_COMMIT_PERF_EN
    checkOutput("perf_stall", 64'(perfStall), 64'd2);
    checkOutput("perf_commit", 64'(perfCommit), 64'd12);
`endif

    // Randomized run against a queue model: pop the head, then append the
    // accepted valid slots oldest-first when the space rule allows.
    for (int c = 0; c < 400; c++) begin
      v  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      w  = 2'($urandom_range(0, 3));
      d0 = {$urandom, $urandom};
      d1 = {$urandom, $urandom};
      r0 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      applyStimulus(v, w, d0, d1, r0, r1);
      #1;
      mReady = (DEPTH - model.size()) >= NREQ;
      checkOutput("rnd.ready", 64'(bus.cmt_ready_o), 64'(mReady));
      @(posedge clk);
      if (model.size() > 0) void'(model.pop_front());
      if (mReady) begin
        if (v[0]) begin e.wren = w[0]; e.data = d0; e.rd = r0; model.push_back(e); end
        if (v[1]) begin e.wren = w[1]; e.data = d1; e.rd = r1; model.push_back(e); end
      end
      #1;
      checkOutput("rnd.count", 64'(bus.count_o), 64'(model.size()));
      checkOutput("rnd.empty", 64'(bus.empty_o), 64'(model.size() == 0));
      checkOutput("rnd.rf_valid", 64'(bus.rf_valid_o), 64'(model.size() != 0));
      if (model.size() != 0) begin
        checkOutput("rnd.rf_data", bus.rf_data_o, model[0].data);
        checkOutput("rnd.rf_rd", 64'(bus.rf_rdindex_o), 64'(model[0].rd));
        checkOutput("rnd.rf_wren", 64'(bus.rf_wren_o), 64'(model[0].wren && (model[0].rd != 5'd0)));
      end else begin
        checkOutput("rnd.rf_data", bus.rf_data_o, 64'd0);
        checkOutput("rnd.rf_wren", 64'(bus.rf_wren_o), 64'd0);
      end
    end

    // Drain, then build count = 3 and reset asynchronously mid-cycle.
    applyStimulus(2'b00, 2'b00, 64'd0, 64'd0, 5'd0, 5'd0);
    repeat (6) @(posedge clk);
    #1;
    applyStimulus(2'b11, 2'b11, 64'h51, 64'h52, 5'd9, 5'd10);
    @(posedge clk);
    #1;
    applyStimulus(2'b11, 2'b11, 64'h53, 64'h54, 5'd11, 5'd12);
    @(posedge clk);
    #1;
    applyStimulus(2'b00, 2'b00, 64'd0, 64'd0, 5'd0, 5'd0);
    checkOutput("mid.count", 64'(bus.count_o), 64'd3);
    checkOutput("mid.rf_data", bus.rf_data_o, 64'h52);
    #2;
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("async_reset");
`ifdef INT_COMMIT_PERF_EN
    checkOutput("async_reset.perf_stall", 64'(perfStall), 64'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      checkIdleOutputs("after_reset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
